ysyx_22050854_axi_rd_responder: RTL and testbench

//  AXI4 read-channel responder (slave end) facing the AXI arbiter's AR channel.
//  It accepts one AR transaction at a time and walks the burst (FIXED/INCR/WRAP).
//  For each beat it issues a read to a synchronous SRAM-style memory port, then

---
 rtl/ysyx_22050854_axi_rd_responder.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_ysyx_22050854_axi_rd_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_axi_rd_responder.sv
// ----------------------------------------------------------------------------
// ysyx_22050854_axi_rd_responder
//
// AXI4 read-channel slave. Accepts one AR transaction at a time, walks the
// burst (FIXED / INCR / WRAP) and, for every beat, issues one read on a
// synchronous SRAM-style port before returning the beat on the R channel with
// the transaction's id, response code and last marker.
//
// The response class is decided once, at the AR handshake:
//   DECERR - start address outside [BASE_ADDR, BASE_ADDR + MEM_BYTES)
//   SLVERR - reserved burst, beat size wider than the data bus, or a WRAP
//            burst whose length is not 2/4/8/16 beats
//   OKAY   - otherwise
// Error bursts still return len+1 beats (zero data, no memory reads).
//
// Ports
//   clock_i        clock, rising edge
//   reset_i        synchronous reset, active low
//   arvalid_i      AR valid
//   arready_o      AR ready (high only in IDLE and out of reset)
//   arid_i         AR id
//   araddr_i       AR start byte address
//   arlen_i        AR beats - 1
//   arsize_i       AR log2(bytes per beat)
//   arburst_i      AR burst type
//   rvalid_o       R valid
//   rready_i       R ready
//   rid_o          R id (echo of arid)
//   rdata_o        R data
//   rresp_o        R response
//   rlast_o        R last beat marker
//   mem_ren_o      memory read strobe, one cycle per OKAY beat
//   mem_raddr_o    memory read address, aligned to the data bus width
//   mem_rdata_i    memory read data, valid the cycle after mem_ren_o
// ----------------------------------------------------------------------------
module ysyx_22050854_axi_rd_responder #(
    parameter int unsigned DATA_W    = 128,
    parameter int unsigned ID_W      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] MEM_BYTES = 32'h0800_0000,
    parameter int unsigned LATENCY   = 0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              arvalid_i,
    output logic              arready_o,
    input  logic [ID_W-1:0]   arid_i,
    input  logic [31:0]       araddr_i,
    input  logic [7:0]        arlen_i,
    input  logic [2:0]        arsize_i,
    input  logic [1:0]        arburst_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [ID_W-1:0]   rid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        rresp_o,
    output logic              rlast_o,
    output logic              mem_ren_o,
    output logic [31:0]       mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned BEAT_BYTES = DATA_W / 8;
    localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);
    localparam logic [2:0]  MAX_SIZE   = 3'(OFF_W);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [7:0]  WAIT_INIT  = 8'(LATENCY);
    localparam logic        HAS_WAIT   = (LATENCY != 32'd0);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DATA  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // Response class of a whole burst, decided from the AR request alone.
    function automatic logic [1:0] classify(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic       wrap_len_ok;
        logic [1:0] resp;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        // Unsigned offset from the base also rejects addresses below it.
        if ((addr - BASE_ADDR) >= MEM_BYTES) begin
            resp = RESP_DECERR;
        end else if ((burst == BURST_RSVD) || (size > MAX_SIZE) ||
                     ((burst == BURST_WRAP) && !wrap_len_ok)) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

    // Address of the following beat. WRAP keeps the address inside the
    // naturally aligned (len+1)*size window, which is a power of two.
    function automatic logic [31:0] advance(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [31:0] step;
        logic [31:0] span;
        logic [31:0] nxt;
        step = 32'd1 << size;
        span = ({24'd0, len} + 32'd1) << size;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = addr + step;
            BURST_WRAP:  nxt = (addr & ~(span - 32'd1)) | ((addr + step) & (span - 32'd1));
            default:     nxt = addr + step;
        endcase
        return nxt;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        burst_q, burst_d;
    logic [1:0]        class_q, class_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        wait_q, wait_d;
    logic              rvalid_q, rvalid_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;
    logic              mem_ren_q, mem_ren_d;
    logic [31:0]       mem_raddr_q, mem_raddr_d;
    logic              ar_hs_s;
    logic              issue_s;

    // arready drops in the same cycle reset is asserted, not one cycle later.
    assign arready_o = (state_q == ST_IDLE) && reset_i;
    assign ar_hs_s   = arvalid_i && arready_o;

    assign rvalid_o    = rvalid_q;
    assign rid_o       = rid_q;
    assign rdata_o     = rdata_q;
    assign rresp_o     = rresp_q;
    assign rlast_o     = rlast_q;
    assign mem_ren_o   = mem_ren_q;
    assign mem_raddr_o = mem_raddr_q;

    // State register.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    state_d = HAS_WAIT ? ST_WAIT : ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_q <= 8'd1) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ISSUE: state_d = ST_DATA;
            ST_DATA:  state_d = ST_RESP;
            ST_RESP: begin
                if (rready_i) begin
                    state_d = rlast_q ? ST_IDLE : ST_ISSUE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Burst context and next values of the registered outputs.
    always_comb begin
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        class_d     = class_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        rvalid_d    = rvalid_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        mem_ren_d   = 1'b0;
        mem_raddr_d = mem_raddr_q;
        issue_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ar_hs_s) begin
                    id_d    = arid_i;
                    addr_d  = araddr_i;
                    len_d   = arlen_i;
                    size_d  = arsize_i;
                    burst_d = arburst_i;
                    class_d = classify(araddr_i, arlen_i, arsize_i, arburst_i);
                    cnt_d   = 8'd0;
                    wait_d  = WAIT_INIT;
                end else begin
                    wait_d = wait_q;
                end
            end
            ST_WAIT: begin
                if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end else begin
                    wait_d = 8'd0;
                end
            end
            ST_ISSUE: begin
                rvalid_d = 1'b0;
            end
            ST_DATA: begin
                // Memory data is only meaningful when a read was issued.
                if (class_q == RESP_OKAY) begin
                    rdata_d = mem_rdata_i;
                end else begin
                    rdata_d = {DATA_W{1'b0}};
                end
                rvalid_d = 1'b1;
                rid_d    = id_q;
                rresp_d  = class_q;
                rlast_d  = (cnt_q == len_q);
            end
            ST_RESP: begin
                if (rready_i) begin
                    rvalid_d = 1'b0;
                    if (rlast_q) begin
                        rlast_d = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + 8'd1;
                        addr_d = advance(addr_q, len_q, size_q, burst_q);
                    end
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                rvalid_d = 1'b0;
            end
        endcase

        // The read strobe is registered, so it is raised on entry to ISSUE
        // using the address and class that will be current there.
        issue_s = (state_d == ST_ISSUE) && (class_d == RESP_OKAY);
        if (issue_s) begin
            mem_ren_d   = 1'b1;
            mem_raddr_d = align(addr_d);
        end else begin
            mem_ren_d   = 1'b0;
            mem_raddr_d = mem_raddr_q;
        end
    end

    // Burst context and output registers.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            id_q        <= {ID_W{1'b0}};
            addr_q      <= 32'd0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'd0;
            class_q     <= 2'd0;
            cnt_q       <= 8'd0;
            wait_q      <= 8'd0;
            rvalid_q    <= 1'b0;
            rid_q       <= {ID_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            rresp_q     <= 2'd0;
            rlast_q     <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= 32'd0;
        end else begin
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            class_q     <= class_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
            mem_ren_q   <= mem_ren_d;
            mem_raddr_q <= mem_raddr_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_axi_rd_responder.sv
module tb_ysyx_22050854_axi_rd_responder;

    logic clock;
    logic reset_m;
    logic sel;

    logic         arvalid_m, rready_m;
    logic [3:0]   arid_m;
    logic [31:0]  araddr_m;
    logic [7:0]   arlen_m;
    logic [2:0]   arsize_m;
    logic [1:0]   arburst_m;

    logic         arvalid_a, arready_a, rvalid_a, rlast_a, mem_ren_a;
    logic [3:0]   rid_a;
    logic [127:0] rdata_a, mem_rdata_a;
    logic [1:0]   rresp_a;
    logic [31:0]  mem_raddr_a;

    logic         arvalid_b, arready_b, rvalid_b, rlast_b, mem_ren_b;
    logic [3:0]   rid_b;
    logic [63:0]  rdata_b, mem_rdata_b;
    logic [1:0]   rresp_b;
    logic [31:0]  mem_raddr_b;
    logic [127:0] pat_b;

    logic         arready_m, rvalid_m, rlast_m, mem_ren_m;
    logic [3:0]   rid_m;
    logic [127:0] rdata_m;
    logic [1:0]   rresp_m;
    logic [31:0]  mem_raddr_m;

    int checks = 0;
    int errors = 0;

    // A: 128-bit bus, default window, no latency. B: 64-bit bus, small window, LATENCY=5.
    ysyx_22050854_axi_rd_responder #(
        .DATA_W(128), .ID_W(4), .BASE_ADDR(32'h8000_0000), .MEM_BYTES(32'h0800_0000), .LATENCY(0)
    ) dut_a (
        .clock_i(clock), .reset_i(reset_m),
        .arvalid_i(arvalid_a), .arready_o(arready_a), .arid_i(arid_m), .araddr_i(araddr_m),
        .arlen_i(arlen_m), .arsize_i(arsize_m), .arburst_i(arburst_m),
        .rvalid_o(rvalid_a), .rready_i(rready_m), .rid_o(rid_a), .rdata_o(rdata_a),
        .rresp_o(rresp_a), .rlast_o(rlast_a),
        .mem_ren_o(mem_ren_a), .mem_raddr_o(mem_raddr_a), .mem_rdata_i(mem_rdata_a)
    );

    ysyx_22050854_axi_rd_responder #(
        .DATA_W(64), .ID_W(4), .BASE_ADDR(32'hA000_0000), .MEM_BYTES(32'h0000_1000), .LATENCY(5)
    ) dut_b (
        .clock_i(clock), .reset_i(reset_m),
        .arvalid_i(arvalid_b), .arready_o(arready_b), .arid_i(arid_m), .araddr_i(araddr_m),
        .arlen_i(arlen_m), .arsize_i(arsize_m), .arburst_i(arburst_m),
        .rvalid_o(rvalid_b), .rready_i(rready_m), .rid_o(rid_b), .rdata_o(rdata_b),
        .rresp_o(rresp_b), .rlast_o(rlast_b),
        .mem_ren_o(mem_ren_b), .mem_raddr_o(mem_raddr_b), .mem_rdata_i(mem_rdata_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [127:0] pat(input logic [31:0] a);
        return {a ^ 32'hC0DE_0000, ~a, a + 32'h1111_1111, a ^ 32'h0F0F_0F0F};
    endfunction

    assign pat_b = pat(mem_raddr_b);

    // Memory models: data for a read one cycle after the strobe, noise otherwise.
    always @(posedge clock) begin
        if (mem_ren_a) mem_rdata_a <= pat(mem_raddr_a);
        else           mem_rdata_a <= {$urandom, $urandom, $urandom, $urandom};
    end
    always @(posedge clock) begin
        if (mem_ren_b) mem_rdata_b <= pat_b[63:0];
        else           mem_rdata_b <= {$urandom, $urandom};
    end

    assign arvalid_a   = arvalid_m && (sel == 1'b0);
    assign arvalid_b   = arvalid_m && (sel == 1'b1);
    assign arready_m   = sel ? arready_b   : arready_a;
    assign rvalid_m    = sel ? rvalid_b    : rvalid_a;
    assign rlast_m     = sel ? rlast_b     : rlast_a;
    assign mem_ren_m   = sel ? mem_ren_b   : mem_ren_a;
    assign rid_m       = sel ? rid_b       : rid_a;
    assign rdata_m     = sel ? {64'd0, rdata_b} : rdata_a;
    assign rresp_m     = sel ? rresp_b     : rresp_a;
    assign mem_raddr_m = sel ? mem_raddr_b : mem_raddr_a;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [1:0] exp_resp(input int d, input logic [31:0] a, input int len,
                                            input int size, input logic [1:0] burst);
        longint unsigned base, lim;
        int bytes;
        base  = d ? 64'hA000_0000 : 64'h8000_0000;
        lim   = base + (d ? 64'h0000_1000 : 64'h0800_0000);
        bytes = d ? 8 : 16;
        if (a < base || a >= lim) return 2'b11;
        if (burst == 2'b11) return 2'b10;
        if ((1 << size) > bytes) return 2'b10;
        if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                              input logic [1:0] burst, input int i);
        longint unsigned s, t, base, off, av;
        s  = 64'd1 << size;
        av = a;
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            t    = (len + 1) * s;
            base = av - (av % t);
            off  = (av - base + i * s) % t;
            return 32'(base + off);
        end
        return 32'(av + i * s);
    endfunction

    function automatic logic [31:0] align(input int d, input logic [31:0] a);
        logic [31:0] bytes;
        bytes = d ? 32'd8 : 32'd16;
        return a & ~(bytes - 32'd1);
    endfunction

    function automatic logic [127:0] exp_data(input int d, input logic [31:0] a, input logic [1:0] resp);
        logic [127:0] v;
        v = pat(align(d, a));
        if (resp != 2'b00) v = 128'd0;
        else if (d == 1) v = {64'd0, v[63:0]};
        return v;
    endfunction

    // Runs one burst on DUT d, checking every beat, every read strobe and the
    // R-channel timing. mode: 0 rready high, 1 random rready, 2 stall beat 0 ten cycles.
    task automatic run_burst(input int d, input logic [3:0] id, input logic [31:0] a, input int len,
                             input int size, input logic [1:0] burst, input int mode,
                             input bit use_tab, input logic [1:0] t_resp,
                             input logic [31:0] t_a0, input logic [31:0] t_a1);
        logic [1:0]   er;
        logic [31:0]  ba;
        int           beat, nren, p, last_p, stall, viol, lat, k;
        bit           hs, prev_pend, prev_rv, first_seen;
        logic [7:0]   pctl;
        logic [127:0] pdata;

        er  = exp_resp(d, a, len, size, burst);
        lat = d ? 7 : 2;
        @(negedge clock);
        sel = d[0];
        arid_m = id; araddr_m = a; arlen_m = 8'(len); arsize_m = 3'(size); arburst_m = burst;
        arvalid_m = 1'b1;
        hs = 0;
        for (k = 0; k < 20; k++) begin
            if (arready_m) begin
                hs = 1;
                break;
            end
            @(negedge clock);
        end
        if (!hs) begin
            chk("ar_accept_timeout", 1'b0, 1'b1);
            arvalid_m = 1'b0;
            return;
        end
        @(posedge clock);
        #1 arvalid_m = 1'b0;

        beat = 0; nren = 0; p = 0; last_p = 0; stall = 0; viol = 0;
        prev_pend = 0; prev_rv = 0; pctl = 8'd0; pdata = 128'd0;
        while (beat <= len && p < 600) begin
            @(negedge clock);
            if (prev_pend) begin
                chk("stall_hold_ctl", {rvalid_m, rid_m, rresp_m, rlast_m}, pctl);
                chk("stall_hold_data", rdata_m, pdata);
            end
            if (mem_ren_m) begin
                if (rvalid_m) viol++;
                ba = align(d, beat_addr(a, len, size, burst, nren));
                chk("mem_raddr", mem_raddr_m, ba);
                if (use_tab && nren == 0) chk("tab_addr0", mem_raddr_m, t_a0);
                if (use_tab && nren == 1) chk("tab_addr1", mem_raddr_m, t_a1);
                nren++;
            end
            if (arready_m) viol++;
            case (mode)
                0:       rready_m = 1'b1;
                1:       rready_m = 1'($urandom_range(0, 1));
                default: rready_m = !(beat == 0 && stall < 10);
            endcase
            first_seen = rvalid_m && !prev_rv;
            if (rvalid_m) begin
                if (first_seen && beat == 0) chk("first_rvalid_lat", p, lat);
                if (first_seen && beat > 0 && mode == 0) chk("beat_gap", p - last_p, 3);
                if (first_seen) last_p = p;
                if (!rready_m) stall++;
                if (rready_m) begin
                    ba = beat_addr(a, len, size, burst, beat);
                    chk("rid", rid_m, id);
                    chk("rresp", rresp_m, er);
                    chk("rdata", rdata_m, exp_data(d, ba, er));
                    chk("rlast", rlast_m, (beat == len));
                    if (use_tab && beat == 0) chk("tab_rresp", rresp_m, t_resp);
                    beat++;
                end
            end
            prev_pend = rvalid_m && !rready_m;
            prev_rv   = rvalid_m;
            pctl      = {rvalid_m, rid_m, rresp_m, rlast_m};
            pdata     = rdata_m;
            @(posedge clock);
            p++;
        end
        if (beat <= len) chk("burst_timeout_beats", beat, len + 1);
        @(negedge clock);
        chk("end_idle", {arready_m, rvalid_m, rlast_m}, 3'b100);
        chk("ren_count", nren, (er == 2'b00) ? len + 1 : 0);
        chk("protocol_viol", viol, 0);
        if (mode == 2) chk("stall_cycles", stall, 10);
    endtask

    typedef struct {
        int          d;
        logic [3:0]  id;
        logic [31:0] addr;
        int          len;
        int          size;
        logic [1:0]  burst;
        int          mode;
        logic [1:0]  resp;
        logic [31:0] a0;
        logic [31:0] a1;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, k;
        vecs[0]  = '{0, 4'd1, 32'h8000_0000, 1, 4, 2'b01, 0, 2'b00, 32'h8000_0000, 32'h8000_0010};
        vecs[1]  = '{1, 4'd3, 32'hA000_0004, 0, 2, 2'b00, 0, 2'b00, 32'hA000_0000, 32'h0};
        vecs[2]  = '{1, 4'd5, 32'hA000_0038, 3, 3, 2'b10, 0, 2'b00, 32'hA000_0038, 32'hA000_0020};
        vecs[3]  = '{0, 4'd2, 32'h0000_1000, 1, 2, 2'b01, 0, 2'b11, 32'h0, 32'h0};
        vecs[4]  = '{0, 4'd4, 32'h8000_0100, 2, 2, 2'b11, 0, 2'b10, 32'h0, 32'h0};
        vecs[5]  = '{0, 4'd6, 32'h8000_0100, 1, 5, 2'b01, 0, 2'b10, 32'h0, 32'h0};
        vecs[6]  = '{0, 4'd7, 32'h8000_0100, 2, 2, 2'b10, 0, 2'b10, 32'h0, 32'h0};
        vecs[7]  = '{0, 4'd8, 32'h8800_0000, 0, 4, 2'b01, 0, 2'b11, 32'h0, 32'h0};
        vecs[8]  = '{0, 4'd9, 32'h87FF_FFF0, 0, 4, 2'b01, 0, 2'b00, 32'h87FF_FFF0, 32'h0};
        vecs[9]  = '{0, 4'hA, 32'h8000_1000, 2, 4, 2'b01, 2, 2'b00, 32'h8000_1000, 32'h8000_1010};
        vecs[10] = '{0, 4'hB, 32'h8000_0204, 3, 2, 2'b00, 0, 2'b00, 32'h8000_0200, 32'h8000_0200};

        sel = 1'b0; reset_m = 1'b0; arvalid_m = 1'b0; rready_m = 1'b0;
        arid_m = 4'd0; araddr_m = 32'd0; arlen_m = 8'd0; arsize_m = 3'd0; arburst_m = 2'd0;
        repeat (3) @(negedge clock);
        chk("rst_a_ctrl", {arready_m, rvalid_m, rid_m, rresp_m, rlast_m, mem_ren_m, mem_raddr_m}, 0);
        chk("rst_a_data", rdata_m, 0);
        sel = 1'b1;
        #1 chk("rst_b_ctrl", {arready_m, rvalid_m, rid_m, rresp_m, rlast_m, mem_ren_m, mem_raddr_m}, 0);
        reset_m = 1'b1;
        @(negedge clock);
        chk("rst_rel_arready_b", arready_m, 1'b1);

        for (int i = 0; i < 11; i++) begin
            run_burst(vecs[i].d, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                      vecs[i].mode, 1'b1, vecs[i].resp, vecs[i].a0, vecs[i].a1);
        end

        for (int n = 0; n < 30; n++) begin
            int d, r, len, size, maxs;
            logic [1:0]  burst;
            logic [31:0] a;
            d = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            burst = (r < 4) ? 2'b01 : (r < 6) ? 2'b00 : (r < 9) ? 2'b10 : 2'b11;
            maxs = d ? 3 : 4;
            size = ($urandom_range(0, 7) == 0) ? maxs + 1 : $urandom_range(0, maxs);
            if (burst == 2'b10) begin
                r = $urandom_range(0, 4);
                len = (r == 0) ? 2 : (r == 1) ? 1 : (r == 2) ? 3 : (r == 3) ? 7 : 15;
            end else begin
                len = $urandom_range(0, 7);
            end
            if (d == 1) a = 32'hA000_0000 + $urandom_range(0, 32'h0000_0FFF);
            else        a = 32'h8000_0000 + $urandom_range(0, 32'h07FF_FFFF);
            r = $urandom_range(0, 9);
            if (r == 0) a = (d == 1) ? 32'h9FFF_FFFC : 32'h7FFF_FFF0;
            if (r == 1) a = (d == 1) ? 32'hA000_1000 : 32'h8800_0008;
            run_burst(d, 4'($urandom_range(0, 15)), a, len, size, burst, $urandom_range(0, 1),
                      1'b0, 2'b00, 32'h0, 32'h0);
        end

        // Reset while DUT B is counting its start-up latency.
        @(negedge clock);
        sel = 1'b1; rready_m = 1'b1;
        arid_m = 4'd9; araddr_m = 32'hA000_0200; arlen_m = 8'd1; arsize_m = 3'd3; arburst_m = 2'b01;
        chk("seqw_arready", arready_m, 1'b1);
        arvalid_m = 1'b1;
        @(posedge clock);
        #1 arvalid_m = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("seqw_in_wait", {rvalid_m, mem_ren_m, arready_m}, 3'b000);
        reset_m = 1'b0;
        @(negedge clock);
        chk("seqw_rst_ctrl", {arready_m, rvalid_m, rid_m, rresp_m, rlast_m, mem_ren_m, mem_raddr_m}, 0);
        chk("seqw_rst_data", rdata_m, 0);
        reset_m = 1'b1;
        @(negedge clock);
        chk("seqw_arready_rel", arready_m, 1'b1);
        cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (rvalid_m || mem_ren_m) cnt++;
        end
        chk("seqw_no_beats", cnt, 0);

        // Reset on DUT A while a beat is waiting for rready.
        sel = 1'b0; rready_m = 1'b0;
        arid_m = 4'd6; araddr_m = 32'h8000_0400; arlen_m = 8'd3; arsize_m = 3'd4; arburst_m = 2'b01;
        arvalid_m = 1'b1;
        @(posedge clock);
        #1 arvalid_m = 1'b0;
        k = 0;
        while (!rvalid_m && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk("seqm_rvalid_seen", rvalid_m, 1'b1);
        chk("seqm_data", rdata_m, pat(32'h8000_0400));
        @(negedge clock);
        reset_m = 1'b0;
        @(negedge clock);
        chk("seqm_rst_ctrl", {arready_m, rvalid_m, rid_m, rresp_m, rlast_m, mem_ren_m, mem_raddr_m}, 0);
        chk("seqm_rst_data", rdata_m, 0);
        reset_m = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clock);
            if (rvalid_m || mem_ren_m) cnt++;
        end
        chk("seqm_no_beats", cnt, 0);
        run_burst(0, 4'hC, 32'h8000_0800, 1, 4, 2'b01, 0, 1'b1, 2'b00, 32'h8000_0800, 32'h8000_0810);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
